// File: rtl/rtl_arb_pkg.sv
// ---------------------------------------------------------------------------
// rtl_arb_pkg
// Shared definitions for the round-robin arbiter that feeds the RTL_unq1
// datapath: default sizing, the operand pair carried by one beat, and the
// modulo pointer increment used by both the picker and the top.
// ---------------------------------------------------------------------------
package rtl_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int WIDTH_DEF   = 5;

    // One beat worth of operands as presented to the datapath.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] in1;
        logic [WIDTH_DEF-1:0] in2;
    } operand_t;

    // Increment an index and wrap it back to zero at n, so NUM_REQ need not
    // be a power of two.
    function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rtl_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting at ptr_i it walks the request
// vector in wrap-around order and reports the first asserted index, which is
// the same result as rotate / priority-encode / unrotate.
// Ports:
//   req_i   in   NUM_REQ   request vector
//   ptr_i   in   ID_W      highest-priority index this cycle
//   pick_o  out  ID_W      selected index (0 when nothing is requesting)
//   any_o   out  1         at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick
    import rtl_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    pick_o,
    output logic               any_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Visit ptr, ptr+1, ... (mod NUM_REQ) and latch the first requester seen;
    // later candidates are ignored once one has been found.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = ptr_i;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                pick_o = idx;
            end
            idx = ID_W'(next_ptr(32'(idx), NUM_REQ));
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rtl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rtl_rr_arbiter
// Round-robin arbiter sharing one RTL_unq1 datapath between NUM_REQ
// ready/valid requesters. A single registered output stage holds the winning
// beat together with the id of the requester it came from, so responses can
// be routed back.
// Ports:
//   CLK        in   1              clock, all state on posedge
//   RESET      in   1              synchronous, active-high reset
//   req_valid  in   NUM_REQ        per-requester valid
//   req_ready  out  NUM_REQ        per-requester ready (at most one bit set)
//   req_in1    in   NUM_REQ*WIDTH  operand 1, requester k at [k*WIDTH +: WIDTH]
//   req_in2    in   NUM_REQ*WIDTH  operand 2, same packing
//   out_valid  out  1              to datapath handshake_valid
//   out_ready  in   1              from datapath handshake_ready
//   out_in1    out  WIDTH          registered operand 1
//   out_in2    out  WIDTH          registered operand 2
//   out_id     out  ID_W           requester whose beat is in out_*
// ---------------------------------------------------------------------------
module rtl_rr_arbiter
    import rtl_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  WIDTH   = WIDTH_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_in1,
    output logic [WIDTH-1:0]         out_in2,
    output logic [ID_W-1:0]          out_id
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic [ID_W-1:0]  pick;
    logic             any_valid;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any_valid)
    );

    // The stage can take a new beat when it is empty or its current beat is
    // leaving this cycle; reset blocks every handshake in its own cycle.
    assign can_load = ~valid_q | out_ready;
    assign accept   = can_load & any_valid & ~RESET;

    // Ready goes only to the picked requester, and the same index steers that
    // requester's operands toward the stage.
    always_comb begin
        req_ready = '0;
        sel_in1   = '0;
        sel_in2   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == ID_W'(k)) begin
                req_ready[k] = accept;
                sel_in1      = req_in1[k*WIDTH +: WIDTH];
                sel_in2      = req_in2[k*WIDTH +: WIDTH];
            end
        end
    end

    // An accept overwrites the stage (covering drain-and-refill with no bubble)
    // and moves priority to the requester after the winner. A drain without a
    // refill only clears valid, so the last operands and id stay visible.
    always_comb begin
        valid_d = valid_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = 1'b1;
            in1_d   = sel_in1;
            in2_d   = sel_in2;
            id_d    = pick;
            ptr_d   = ID_W'(next_ptr(32'(pick), NUM_REQ));
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Stage and pointer registers; reset drops any beat held in the stage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_in1   = in1_q;
    assign out_in2   = in2_q;
    assign out_id    = id_q;

endmodule
